// File: rtl/apb_uart_fifo_bridge.sv
// APB3 register bridge between an APB master and UART RX/TX byte streams.
// Zero-wait-state slave: an access completes in the cycle penable rises, and its
// side effects (FIFO push/pop, CTRL/CLEAR writes) land on the edge ending that cycle.
// Each direction has its own FIFO. TX is first-word-fall-through towards the UART.
module apb_uart_fifo_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                  pclk,
    input  logic                  prstn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam logic [PTR_WIDTH:0] PTR_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0] PTR_FULL = {1'b1, {PTR_WIDTH{1'b0}}};

    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_CLEAR  = 3'd3;
    localparam logic [2:0] OFF_RXLVL  = 3'd4;
    localparam logic [2:0] OFF_TXLVL  = 3'd5;

    logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [PTR_WIDTH:0]    r_tx_wr;
    logic [PTR_WIDTH:0]    r_tx_rd;
    logic [PTR_WIDTH:0]    r_rx_wr;
    logic [PTR_WIDTH:0]    r_rx_rd;
    logic                  r_tx_en;
    logic                  r_rx_en;
    logic                  r_overrun;

    logic                  w_access;
    logic                  w_upper_ok;
    logic [2:0]            w_off;
    logic                  w_sel_data;
    logic                  w_sel_ctrl;
    logic                  w_sel_clear;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic [PTR_WIDTH:0]    w_tx_lvl;
    logic [PTR_WIDTH:0]    w_rx_lvl;
    logic                  w_tx_push;
    logic                  w_tx_pop;
    logic                  w_rx_push;
    logic                  w_rx_pop;
    logic                  w_clr_wr;
    logic                  w_tx_flush;
    logic                  w_rx_flush;
    logic                  w_ovr_clr;
    logic                  w_ovr_set;
    logic                  w_ctrl_wr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_err;
    logic                  w_unused;

    // Gating with prstn keeps pready low while reset is held even if the master is mid-access.
    assign w_access   = pselx & penable & prstn;
    assign w_upper_ok = (paddr[ADDR_WIDTH-1:5] == '0);
    assign w_off      = paddr[4:2];

    assign w_sel_data  = w_access & w_upper_ok & (w_off == OFF_DATA);
    assign w_sel_ctrl  = w_access & w_upper_ok & (w_off == OFF_CTRL);
    assign w_sel_clear = w_access & w_upper_ok & (w_off == OFF_CLEAR);

    assign w_tx_full  = ((r_tx_wr ^ r_tx_rd) == PTR_FULL);
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_rx_full  = ((r_rx_wr ^ r_rx_rd) == PTR_FULL);
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_tx_lvl   = r_tx_wr - r_tx_rd;
    assign w_rx_lvl   = r_rx_wr - r_rx_rd;

    // Full/empty here are start-of-cycle state, so same-cycle UART traffic cannot rescue an access.
    assign w_tx_push = w_sel_data & pwrite & ~w_tx_full;
    assign w_rx_pop  = w_sel_data & ~pwrite & ~w_rx_empty;

    assign w_clr_wr   = w_sel_clear & pwrite;
    assign w_tx_flush = w_clr_wr & pwdata[0];
    assign w_rx_flush = w_clr_wr & pwdata[1];
    assign w_ovr_clr  = w_clr_wr & pwdata[2];
    assign w_ctrl_wr  = w_sel_ctrl & pwrite;

    assign rx_ready  = r_rx_en & ~w_rx_full;
    assign w_rx_push = rx_valid & rx_ready;
    assign w_ovr_set = rx_valid & r_rx_en & w_rx_full;

    assign tx_valid = r_tx_en & ~w_tx_empty;
    assign tx_data  = r_tx_mem[r_tx_rd[PTR_WIDTH-1:0]];
    assign w_tx_pop = tx_valid & tx_ready;

    assign pready  = w_access;
    assign prdata  = w_rdata;
    assign pslverr = w_err;

    // Only paddr[4:2] and the low CTRL/CLEAR bits carry meaning.
    assign w_unused = ^{paddr[1:0], pwdata};

    // Register read mux and error decode; both stay 0 outside an access phase.
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_access) begin
            if (!w_upper_ok) begin
                w_err = 1'b1;
            end else begin
                case (w_off)
                    OFF_DATA: begin
                        if (pwrite) begin
                            w_err = w_tx_full;
                        end else if (w_rx_empty) begin
                            w_err = 1'b1;
                        end else begin
                            w_rdata = r_rx_mem[r_rx_rd[PTR_WIDTH-1:0]];
                        end
                    end
                    OFF_STATUS: begin
                        if (pwrite) begin
                            w_err = 1'b1;
                        end else begin
                            w_rdata = DATA_WIDTH'({r_overrun, w_tx_full, w_tx_empty,
                                                   w_rx_full, w_rx_empty});
                        end
                    end
                    OFF_CTRL: begin
                        if (!pwrite) begin
                            w_rdata = DATA_WIDTH'({r_rx_en, r_tx_en});
                        end
                    end
                    OFF_CLEAR: begin
                        w_rdata = '0;
                    end
                    OFF_RXLVL: begin
                        if (pwrite) begin
                            w_err = 1'b1;
                        end else begin
                            w_rdata = DATA_WIDTH'(w_rx_lvl);
                        end
                    end
                    OFF_TXLVL: begin
                        if (pwrite) begin
                            w_err = 1'b1;
                        end else begin
                            w_rdata = DATA_WIDTH'(w_tx_lvl);
                        end
                    end
                    default: begin
                        w_err = 1'b1;
                    end
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty, so no reset.
    always_ff @(posedge pclk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr[PTR_WIDTH-1:0]] <= pwdata;
        end
        if (w_rx_push && !w_rx_flush) begin
            r_rx_mem[r_rx_wr[PTR_WIDTH-1:0]] <= rx_data;
        end
    end

    // TX pointers: a flush wins over a same-cycle UART pop (that byte still counts as sent).
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else if (w_tx_flush) begin
            r_tx_rd <= r_tx_wr;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
        end
    end

    // RX pointers: a flush discards any byte arriving in the same cycle.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
        end else if (w_rx_flush) begin
            r_rx_rd <= r_rx_wr;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
        end
    end

    // CTRL enables and the sticky overrun flag; a set beats a same-cycle clear.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_tx_en   <= 1'b0;
            r_rx_en   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_tx_en <= pwdata[0];
                r_rx_en <= pwdata[1];
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_fifo_bridge.sv
// Bench for apb_uart_fifo_bridge: directed register scenarios followed by randomized
// APB and UART traffic. A queue-based reference model predicts every APB response,
// every TX handshake byte and rx_ready; a separate monitor pops and compares.
module tb_apb_uart_fifo_bridge;

    localparam int DEPTH = 16;

    logic        pclk;
    logic        prstn;
    logic [31:0] paddr;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [7:0]  pwdata;
    logic        pready;
    logic [7:0]  prdata;
    logic        pslverr;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;

    apb_uart_fifo_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .pclk     (pclk),
        .prstn    (prstn),
        .paddr    (paddr),
        .pselx    (pselx),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Reference model state: plain queues of bytes plus the control bits.
    byte unsigned m_rx[$];
    byte unsigned m_tx[$];
    bit           m_tx_en;
    bit           m_rx_en;
    bit           m_ovr;

    typedef struct packed {
        logic       is_read;
        logic [7:0] data;
        logic       err;
    } apb_exp_t;

    apb_exp_t     sb_apb[$];
    byte unsigned sb_tx[$];
    bit           sb_rxr[$];

    // Model scratch
    int unsigned  mo_addr;
    int unsigned  mo_off;
    bit           mo_ok;
    bit           mo_err;
    int unsigned  mo_rd;
    bit           mo_push_tx;
    bit           mo_pop_rx;
    bit           mo_rx_push;
    bit           mo_ovr_set;
    bit           mo_tx_hs;
    bit           mo_wr_ctrl;
    bit           mo_rxr;
    logic [7:0]   mo_clr;
    apb_exp_t     mo_e;

    // Model: evaluates the cycle at the falling edge (inputs stable) and advances to
    // the state the DUT will hold after the next rising edge.
    always @(negedge pclk) begin
        if (!prstn) begin
            m_rx.delete();
            m_tx.delete();
            m_tx_en = 0;
            m_rx_en = 0;
            m_ovr   = 0;
        end else begin
            mo_err = 0; mo_rd = 0; mo_push_tx = 0; mo_pop_rx = 0; mo_rx_push = 0;
            mo_ovr_set = 0; mo_tx_hs = 0; mo_wr_ctrl = 0; mo_clr = 8'h00;
            if (pselx && penable) begin
                mo_addr = paddr;
                mo_ok   = (mo_addr < 32);
                mo_off  = (mo_addr % 32) / 4;
                if (!mo_ok || mo_off > 5) begin
                    mo_err = 1;
                end else if (mo_off == 0) begin
                    if (pwrite) begin
                        if (m_tx.size() == DEPTH) mo_err = 1;
                        else mo_push_tx = 1;
                    end else if (m_rx.size() == 0) begin
                        mo_err = 1;
                    end else begin
                        mo_rd = m_rx[0];
                        mo_pop_rx = 1;
                    end
                end else if (mo_off == 1) begin
                    if (pwrite) mo_err = 1;
                    else mo_rd = (m_rx.size() == 0 ? 1 : 0) + (m_rx.size() == DEPTH ? 2 : 0)
                               + (m_tx.size() == 0 ? 4 : 0) + (m_tx.size() == DEPTH ? 8 : 0)
                               + (m_ovr ? 16 : 0);
                end else if (mo_off == 2) begin
                    if (pwrite) mo_wr_ctrl = 1;
                    else mo_rd = (m_tx_en ? 1 : 0) + (m_rx_en ? 2 : 0);
                end else if (mo_off == 3) begin
                    if (pwrite) mo_clr = pwdata;
                end else if (mo_off == 4) begin
                    if (pwrite) mo_err = 1;
                    else mo_rd = m_rx.size();
                end else begin
                    if (pwrite) mo_err = 1;
                    else mo_rd = m_tx.size();
                end
                mo_e.is_read = !pwrite;
                mo_e.data    = mo_rd[7:0];
                mo_e.err     = mo_err;
                sb_apb.push_back(mo_e);
            end
            mo_tx_hs = m_tx_en && (m_tx.size() > 0) && tx_ready;
            if (mo_tx_hs) sb_tx.push_back(m_tx[0]);
            if (rx_valid) begin
                mo_rxr = m_rx_en && (m_rx.size() < DEPTH);
                sb_rxr.push_back(mo_rxr);
                if (mo_rxr) mo_rx_push = 1;
                else if (m_rx_en) mo_ovr_set = 1;
            end
            if (mo_tx_hs) void'(m_tx.pop_front());
            if (mo_push_tx) m_tx.push_back(pwdata);
            if (mo_clr[0]) m_tx.delete();
            if (mo_pop_rx) void'(m_rx.pop_front());
            if (mo_rx_push) m_rx.push_back(rx_data);
            if (mo_clr[1]) m_rx.delete();
            if (mo_clr[2]) m_ovr = 0;
            if (mo_ovr_set) m_ovr = 1;
            if (mo_wr_ctrl) begin
                m_tx_en = pwdata[0];
                m_rx_en = pwdata[1];
            end
        end
    end

    apb_exp_t     mn_e;
    byte unsigned mn_b;
    bit           mn_r;

    // Monitor: pops an expectation whenever the DUT presents a response or handshake.
    always @(negedge pclk) begin
        #1;
        if (prstn) begin
            if (pready) begin
                if (sb_apb.size() == 0) begin
                    check("apb_unexpected_pready", 32'd1, 32'd0);
                end else begin
                    mn_e = sb_apb.pop_front();
                    if (mn_e.is_read) check("apb_prdata", {24'd0, prdata}, {24'd0, mn_e.data});
                    check("apb_pslverr", {31'd0, pslverr}, {31'd0, mn_e.err});
                end
            end else begin
                check("apb_idle_outputs", {23'd0, prdata, pslverr}, 32'd0);
            end
            if (tx_valid && tx_ready) begin
                if (sb_tx.size() == 0) begin
                    check("tx_unexpected_handshake", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    mn_b = sb_tx.pop_front();
                    check("tx_data", {24'd0, tx_data}, {24'd0, mn_b});
                end
            end
            if (rx_valid) begin
                if (sb_rxr.size() == 0) begin
                    check("rx_ready_no_expectation", 32'd1, 32'd0);
                end else begin
                    mn_r = sb_rxr.pop_front();
                    check("rx_ready", {31'd0, rx_ready}, {31'd0, mn_r});
                end
            end
        end
    end

    bit rand_uart = 0;

    task automatic cyc();
        @(posedge pclk);
        #1;
        if (rand_uart) begin
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic apb(input logic [31:0] addr, input bit wr, input logic [7:0] wd,
                       output logic [7:0] rd, output logic err);
        cyc();
        pselx = 1; penable = 0; paddr = addr; pwrite = wr; pwdata = wd;
        cyc();
        penable = 1;
        @(negedge pclk);
        #2;
        rd  = prdata;
        err = pslverr;
        cyc();
        pselx = 0; penable = 0;
    endtask

    task automatic rd_chk(string name, logic [31:0] addr, logic [7:0] exp_d, logic exp_e);
        logic [7:0] d;
        logic       e;
        apb(addr, 1'b0, 8'h00, d, e);
        check(name, {23'd0, e, d}, {23'd0, exp_e, exp_d});
    endtask

    task automatic wr_chk(string name, logic [31:0] addr, logic [7:0] wd, logic exp_e);
        logic [7:0] d;
        logic       e;
        apb(addr, 1'b1, wd, d, e);
        check(name, {31'd0, e}, {31'd0, exp_e});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    logic [7:0] t_d;
    logic       t_e;
    int         t_r;

    initial begin
        prstn = 0; paddr = 0; pselx = 1; penable = 1; pwrite = 0; pwdata = 0;
        rx_valid = 0; rx_data = 0; tx_ready = 0;

        // 1: outputs held low during reset even with an access pending
        repeat (2) @(posedge pclk);
        @(negedge pclk); #2;
        check("reset_outputs", {18'd0, pready, prdata, pslverr, rx_ready, tx_valid,
                                tx_data != tx_data}, 32'd0);
        cyc();
        pselx = 0; penable = 0;
        cyc();
        prstn = 1;
        rd_chk("status_after_reset", 32'h04, 8'h05, 1'b0);
        rd_chk("ctrl_after_reset", 32'h08, 8'h00, 1'b0);
        check("rx_ready_tx_valid_after_reset", {30'd0, rx_ready, tx_valid}, 32'd0);

        // 2: TX ordering, and tx_data held while the UART stalls
        wr_chk("ctrl_write_3", 32'h08, 8'h03, 1'b0);
        wr_chk("tx_write_a5", 32'h00, 8'hA5, 1'b0);
        wr_chk("tx_write_3c", 32'h00, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk); #2;
            check("tx_hold_while_stalled", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
        end
        cyc();
        tx_ready = 1;
        repeat (4) cyc();
        tx_ready = 0;
        rd_chk("txlvl_after_drain", 32'h14, 8'h00, 1'b0);

        // 3: RX fill to depth, overrun on the 17th byte, read back in order
        wr_chk("ctrl_write_2", 32'h08, 8'h02, 1'b0);
        for (int i = 0; i <= DEPTH; i++) begin
            cyc();
            rx_valid = 1;
            rx_data  = 8'(i);
        end
        cyc();
        rx_valid = 0;
        rd_chk("rxlvl_full", 32'h10, 8'h10, 1'b0);
        rd_chk("status_rx_full_overrun", 32'h04, 8'h16, 1'b0);
        for (int i = 0; i < DEPTH; i++) rd_chk("rx_read_order", 32'h00, 8'(i), 1'b0);
        rd_chk("rx_read_empty", 32'h00, 8'h00, 1'b1);
        wr_chk("clear_overrun", 32'h0C, 8'h04, 1'b0);
        rd_chk("status_overrun_cleared", 32'h04, 8'h05, 1'b0);

        // 4: TX fill with tx_en off, overflow error, flush
        wr_chk("ctrl_write_0", 32'h08, 8'h00, 1'b0);
        tx_ready = 1;
        for (int i = 0; i < DEPTH; i++) wr_chk("tx_fill", 32'h00, 8'($urandom), 1'b0);
        wr_chk("tx_overflow", 32'h00, 8'h77, 1'b1);
        rd_chk("txlvl_full", 32'h14, 8'h10, 1'b0);
        rd_chk("status_tx_full", 32'h04, 8'h09, 1'b0);
        wr_chk("clear_flush_tx", 32'h0C, 8'h01, 1'b0);
        rd_chk("txlvl_after_flush", 32'h14, 8'h00, 1'b0);
        rd_chk("status_after_flush", 32'h04, 8'h05, 1'b0);
        tx_ready = 0;

        // 5: bad offsets and nonzero upper address bits
        rd_chk("read_off_18", 32'h18, 8'h00, 1'b1);
        wr_chk("write_off_18", 32'h18, 8'h55, 1'b1);
        rd_chk("read_addr_100", 32'h100, 8'h00, 1'b1);
        wr_chk("write_addr_100", 32'h100, 8'h55, 1'b1);
        wr_chk("write_addr_108", 32'h108, 8'h03, 1'b1);
        rd_chk("txlvl_untouched", 32'h14, 8'h00, 1'b0);
        rd_chk("ctrl_untouched", 32'h08, 8'h00, 1'b0);
        wr_chk("write_status", 32'h04, 8'h00, 1'b1);
        wr_chk("write_rxlvl", 32'h10, 8'h00, 1'b1);
        rd_chk("read_clear", 32'h0C, 8'h00, 1'b0);

        // 6: reset in the middle of an access with both FIFOs at level 5
        wr_chk("ctrl_write_3b", 32'h08, 8'h03, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            rx_valid = 1;
            rx_data  = 8'(8'h40 + i);
        end
        cyc();
        rx_valid = 0;
        for (int i = 0; i < 5; i++) wr_chk("tx_fill5", 32'h00, 8'(8'h80 + i), 1'b0);
        rd_chk("rxlvl_5", 32'h10, 8'h05, 1'b0);
        rd_chk("txlvl_5", 32'h14, 8'h05, 1'b0);
        cyc();
        pselx = 1; penable = 0; paddr = 32'h00; pwrite = 0;
        cyc();
        penable = 1; prstn = 0; rx_valid = 1; tx_ready = 1;
        @(negedge pclk); #2;
        check("outputs_in_reset", {27'd0, pready, prdata != 8'h00, pslverr, rx_ready, tx_valid},
              32'd0);
        cyc();
        pselx = 0; penable = 0; rx_valid = 0; tx_ready = 0;
        cyc();
        prstn = 1;
        rd_chk("rxlvl_after_reset", 32'h10, 8'h00, 1'b0);
        rd_chk("txlvl_after_reset", 32'h14, 8'h00, 1'b0);
        rd_chk("ctrl_after_mid_reset", 32'h08, 8'h00, 1'b0);

        // Randomized traffic on both sides, checked entirely by the model
        rand_uart = 1;
        for (int n = 0; n < 400; n++) begin
            t_r = $urandom_range(0, 19);
            t_d = 8'($urandom);
            if (t_r <= 7) apb(32'h00, $urandom_range(0, 1) == 1, t_d, t_d, t_e);
            else if (t_r <= 9) apb(32'h04, 1'b0, t_d, t_d, t_e);
            else if (t_r <= 11) begin
                if ($urandom_range(0, 3) != 0) t_d = 8'h03;
                apb(32'h08, $urandom_range(0, 1) == 1, t_d, t_d, t_e);
            end
            else if (t_r == 12) apb(32'h0C, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 7)),
                                    t_d, t_e);
            else if (t_r <= 14) apb(32'h10, 1'b0, t_d, t_d, t_e);
            else if (t_r <= 16) apb(32'h14, 1'b0, t_d, t_d, t_e);
            else if (t_r == 17) apb(32'h18, $urandom_range(0, 1) == 1, t_d, t_d, t_e);
            else if (t_r == 18) apb(32'h1C, 1'b0, t_d, t_d, t_e);
            else apb(32'h200, $urandom_range(0, 1) == 1, t_d, t_d, t_e);
        end
        rand_uart = 0;
        cyc();
        rx_valid = 0; tx_ready = 0;
        repeat (3) cyc();

        check("apb_expectations_drained", sb_apb.size(), 32'd0);
        check("tx_expectations_drained", sb_tx.size(), 32'd0);
        check("rx_expectations_drained", sb_rxr.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
